// File: rtl/stream_pool_engine.sv
// stream_pool_engine: streaming KxK non-overlapping max/min/mean pooling over raster-order pixels.
// Build macro POOL_MEAN_ROUND_EN makes mean mode round half-up instead of truncating.
module stream_pool_engine #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 64,
  parameter int MAX_H  = 64,
  parameter int KSIZE  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0]   cfg_height,
  input  logic [1:0]                   cfg_mode,
  input  logic                         s_valid,
  input  logic [DATA_W-1:0]            s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic                         idle,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int WW    = $clog2(MAX_W+1);
  localparam int HW    = $clog2(MAX_H+1);
  localparam int LK    = $clog2(KSIZE);
  localparam int ACC_W = DATA_W + 2*LK;
  localparam int OC_N  = MAX_W / KSIZE;
  localparam int OCW   = (OC_N > 1) ? $clog2(OC_N) : 1;
`ifdef POOL_MEAN_ROUND_EN
  localparam int RND   = 1 << (2*LK - 1);
`else
  localparam int RND   = 0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [WW-1:0]      w_q, w_d, col_q, col_d;
  logic [HW-1:0]      h_q, h_d, row_q, row_d;
  logic [1:0]         mode_q, mode_d;
  logic               mValid_q, mValid_d, mLast_q, mLast_d;
  logic [DATA_W-1:0]  mData_q, mData_d;
  logic [ACC_W-1:0]   acc_q [OC_N];

  logic               cfgOk, accept, inWin, firstPix, closeWin, lastPix, lastOut;
  logic [WW-1:0]      wEff;
  logic [HW-1:0]      hEff;
  logic [OCW-1:0]     ocIdx;
  logic [ACC_W-1:0]   accCur, pixExt, accNew, meanSum;
  logic [DATA_W-1:0]  result;

  assign cfgOk = (cfg_width  >= WW'(KSIZE)) && (cfg_width  <= WW'(MAX_W)) &&
                 (cfg_height >= HW'(KSIZE)) && (cfg_height <= HW'(MAX_H)) &&
                 (cfg_mode != 2'b11);

  assign s_ready  = (state_q == S_RUN) && !(mValid_q && !m_ready);
  assign accept   = s_valid && s_ready;

  // Pixels past the last full window in either direction are consumed but never pooled.
  assign wEff     = w_q & ~WW'(KSIZE-1);
  assign hEff     = h_q & ~HW'(KSIZE-1);
  assign inWin    = (col_q < wEff) && (row_q < hEff);
  assign firstPix = (row_q[LK-1:0] == '0) && (col_q[LK-1:0] == '0);
  assign closeWin = (row_q[LK-1:0] == '1) && (col_q[LK-1:0] == '1);
  assign lastPix  = (col_q == w_q - WW'(1)) && (row_q == h_q - HW'(1));
  assign lastOut  = (col_q == wEff - WW'(1)) && (row_q == hEff - HW'(1));

  assign ocIdx    = OCW'(col_q >> LK);
  assign accCur   = acc_q[ocIdx];
  assign pixExt   = ACC_W'(s_data);

  always_comb begin
    accNew = pixExt;
    if (!firstPix) begin
      case (mode_q)
        2'b00:   accNew = (pixExt > accCur) ? pixExt : accCur;
        2'b10:   accNew = (pixExt < accCur) ? pixExt : accCur;
        2'b01:   accNew = accCur + pixExt;
        default: accNew = pixExt;
      endcase
    end
  end

  // The mean accumulator is sized so the rounding offset can never overflow it.
  assign meanSum = accNew + ACC_W'(RND);
  assign result  = (mode_q == 2'b01) ? DATA_W'(meanSum >> (2*LK)) : accNew[DATA_W-1:0];

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    mode_d   = mode_q;
    col_d    = col_q;
    row_d    = row_q;
    mValid_d = mValid_q && !m_ready;
    mLast_d  = mLast_q && !m_ready;
    mData_d  = mData_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          if (cfgOk) begin
            state_d = S_RUN;
            w_d     = cfg_width;
            h_d     = cfg_height;
            mode_d  = cfg_mode;
            col_d   = '0;
            row_d   = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          if (col_q == w_q - WW'(1)) begin
            col_d = '0;
            row_d = row_q + HW'(1);
          end else begin
            col_d = col_q + WW'(1);
          end
          if (inWin && closeWin) begin
            mValid_d = 1'b1;
            mData_d  = result;
            mLast_d  = lastOut;
          end
          if (lastPix) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!(mValid_q && !m_ready)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      h_q      <= '0;
      mode_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      mValid_q <= 1'b0;
      mLast_q  <= 1'b0;
      mData_q  <= '0;
      for (int i = 0; i < OC_N; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      mode_q   <= mode_d;
      col_q    <= col_d;
      row_q    <= row_d;
      mValid_q <= mValid_d;
      mLast_q  <= mLast_d;
      mData_q  <= mData_d;
      if (accept && inWin) acc_q[ocIdx] <= accNew;
    end
  end

  assign m_valid = mValid_q;
  assign m_data  = mData_q;
  assign m_last  = mLast_q;
  assign idle    = (state_q == S_IDLE);
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign error   = (state_q == S_ERR);

endmodule

// File: tb/tb_stream_pool_engine.sv
// tb_stream_pool_engine: scoreboard bench for the streaming pooler (KSIZE=2, 8x8 max frame).
// Expected windows are computed directly from the whole frame image, then matched as outputs appear.
module tb_stream_pool_engine;

  localparam int K = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cfg_width = '0;
  logic [3:0] cfg_height = '0;
  logic [1:0] cfg_mode = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       idle, busy, done, error;

  int errors = 0;
  int checks = 0;
  int readyMode = 0;
  bit doneExpect = 1'b0;

  typedef struct {
    int data;
    bit last;
    bit doneNext;
  } exp_t;

  exp_t sbq[$];

  stream_pool_engine #(.DATA_W(8), .MAX_W(8), .MAX_H(8), .KSIZE(K)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_mode(cfg_mode),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .idle(idle), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Downstream ready: always on, random, or left to the directed stall test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (readyMode == 0) m_ready = 1'b1;
    end
  end

  // Monitor: every handshake pops the oldest expected window result.
  initial begin
    forever begin
      @(negedge clk);
      if (doneExpect) begin
        checkOutput("done_after_last", int'(done), 1);
        doneExpect = 1'b0;
      end
      if (!rst && m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got data %0d expected none", m_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("m_data", int'(m_data), e.data);
          checkOutput("m_last", int'(m_last), int'(e.last));
          if (e.last && e.doneNext) doneExpect = 1'b1;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doStart(input int w, input int h, input int mode);
    cfg_width  = 4'(w);
    cfg_height = 4'(h);
    cfg_mode   = 2'(mode);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic sendPixel(input int d, input int gaps);
    bit taken = 1'b0;
    int n = 0;
    if (gaps != 0 && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data  = 8'(d);
    while (!taken && n < 300) begin
      @(negedge clk);
      taken = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!taken) checkOutput("pixel_accept_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input int w, input int h, input int mode, input int pattern,
                               input int gaps, input int abortAfter);
    int img[64];
    int n;
    bit seen;
    for (int i = 0; i < w*h; i++) img[i] = (pattern == 0) ? i : int'($urandom_range(0, 255));
    for (int oy = 0; oy < h/K; oy++) begin
      for (int ox = 0; ox < w/K; ox++) begin
        exp_t e;
        int v = (mode == 2) ? 256 : -1;
        int sum = 0;
        for (int dy = 0; dy < K; dy++) begin
          for (int dx = 0; dx < K; dx++) begin
            int p = img[(oy*K + dy)*w + ox*K + dx];
            sum += p;
            if (mode == 0 && p > v) v = p;
            if (mode == 2 && p < v) v = p;
          end
        end
`ifdef POOL_MEAN_ROUND_EN
        if (mode == 1) v = (sum + (K*K)/2) / (K*K);
`else
        if (mode == 1) v = sum / (K*K);
`endif
        e.data     = v;
        e.last     = (oy == h/K - 1) && (ox == w/K - 1);
        e.doneNext = (w % K == 0) && (h % K == 0);
        sbq.push_back(e);
      end
    end
    doStart(w, h, mode);
    checkOutput("start_busy", int'(busy), 1);
    checkOutput("start_error", int'(error), 0);
    n = (abortAfter < 0) ? w*h : abortAfter;
    for (int i = 0; i < n; i++) sendPixel(img[i], gaps);
    s_valid = 1'b0;
    if (abortAfter >= 0) begin
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      checkOutput("abort_outputs_seen", sbq.size(), (w/K)*(h/K) - 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sbq.delete();
      doneExpect = 1'b0;
      checkOutput("midrst_idle", int'(idle), 1);
      checkOutput("midrst_m_valid", int'(m_valid), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      repeat (2) begin
        @(posedge clk);
        #1;
        checkOutput("midrst_no_done", int'(done), 0);
      end
      rst = 1'b0;
      return;
    end
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("frame_done", int'(seen), 1);
    checkOutput("outputs_left", sbq.size(), 0);
    @(posedge clk);
    #1;
    checkOutput("idle_after_frame", int'(idle), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_idle", int'(idle), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_error", int'(error), 0);
    checkOutput("rst_m_valid", int'(m_valid), 0);
    checkOutput("rst_m_last", int'(m_last), 0);
    checkOutput("rst_s_ready", int'(s_ready), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(4, 4, 0, 0, 0, -1);
    applyStimulus(4, 4, 2, 0, 0, -1);
    applyStimulus(4, 4, 1, 0, 0, -1);
    applyStimulus(5, 5, 0, 0, 0, -1);

    // Downstream stalls on the first result; input must back off and the result must hold.
    readyMode = 2;
    m_ready   = 1'b0;
    fork
      applyStimulus(4, 4, 0, 0, 0, -1);
      begin
        bit gotValid = 1'b0;
        for (int c = 0; c < 200 && !gotValid; c++) begin
          @(negedge clk);
          gotValid = m_valid;
        end
        checkOutput("stall_m_valid_seen", int'(gotValid), 1);
        for (int c = 0; c < 5; c++) begin
          checkOutput("stall_s_ready", int'(s_ready), 0);
          checkOutput("stall_m_data", int'(m_data), 5);
          if (c < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        readyMode = 0;
        m_ready   = 1'b1;
      end
    join

    doStart(4, 4, 3);
    checkOutput("bad_mode_error", int'(error), 1);
    checkOutput("bad_mode_s_ready", int'(s_ready), 0);
    checkOutput("bad_mode_idle", int'(idle), 0);
    doStart(1, 4, 0);
    checkOutput("bad_width_small_error", int'(error), 1);
    doStart(4, 9, 0);
    checkOutput("bad_height_big_error", int'(error), 1);
    applyStimulus(4, 4, 0, 0, 0, -1);

    applyStimulus(4, 4, 0, 0, 0, 6);
    applyStimulus(4, 4, 0, 0, 0, -1);

    readyMode = 1;
    for (int f = 0; f < 10; f++) begin
      applyStimulus(int'($urandom_range(2, 8)), int'($urandom_range(2, 8)),
                    int'($urandom_range(0, 2)), 1, 1, -1);
    end
    readyMode = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
